// File: rtl/burst_ram_if.sv
// burst_ram_if: request/beat bus between a burst master and burst_ram
interface burst_ram_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int LEN_W = 4
);
  logic cen, wen;
  logic [ADDR_W-1:0] s_addr;
  logic [LEN_W-1:0] s_len;
  logic [DATA_W/8-1:0] s_be;
  logic [DATA_W-1:0] s_din, s_dout;
  logic s_dvalid, busy, done;
  modport master (output cen, wen, s_addr, s_len, s_be, s_din, input s_dout, s_dvalid, busy, done);
  modport slave (input cen, wen, s_addr, s_len, s_be, s_din, output s_dout, s_dvalid, busy, done);
endinterface

// File: rtl/burst_ram.sv
// burst_ram: byte-masked RAM executing wrapping read/write bursts, one beat per cycle
module burst_ram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int LEN_W = 4
) (
  input logic clk,
  input logic rst,
  burst_ram_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB = DATA_W/8;
  typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, beat_addr;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic dvalid_q, dvalid_d, done_q, done_d;
  logic idle, go, wr, last;
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  // Beat 0 runs on the accept edge straight from the request fields; the
  // cycle right after a final beat never accepts, forcing an idle gap.
  always_comb begin
    idle = state_q == IDLE;
    go = idle ? bus.cen && !done_q : 1'b1;
    wr = idle ? bus.wen : state_q == WBURST;
    last = idle ? bus.s_len == '0 : cnt_q == len_q;
    beat_addr = idle ? bus.s_addr : addr_q + ADDR_W'(cnt_q);
    addr_d = idle ? bus.s_addr : addr_q;
    len_d = idle ? bus.s_len : len_q;
    cnt_d = go && !last ? cnt_q + 1'b1 : '0;
    state_d = !go || last ? IDLE : (wr ? WBURST : RBURST);
    dvalid_d = go && !wr;
    dout_d = dvalid_d ? mem[beat_addr] : '0;
    done_d = go && last;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      dout_q <= '0;
      dvalid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
      dvalid_q <= dvalid_d;
      done_q <= done_d;
    end
  end
  // Storage has no reset; the rst gate keeps a request during reset from writing.
  always_ff @(posedge clk)
    for (int i = 0; i < NB; i++)
      if (!rst && go && wr && bus.s_be[i]) mem[beat_addr][i*8 +: 8] <= bus.s_din[i*8 +: 8];
  assign bus.busy = state_q != IDLE;
  assign bus.s_dout = dout_q;
  assign bus.s_dvalid = dvalid_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_burst_ram.sv
// tb_burst_ram: directed + randomized bursts checked against a flat-array memory model
module tb_burst_ram;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [63:0] ref_mem [256];
  logic [63:0] bd [16];
  logic [7:0] bbe [16];
  burst_ram_if #(.DATA_W(64), .ADDR_W(8), .LEN_W(4)) bus ();
  burst_ram #(.DATA_W(64), .ADDR_W(8), .LEN_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
    chk({tag, ".dvalid"}, 64'(bus.s_dvalid), 64'd0);
    chk({tag, ".done"}, 64'(bus.done), 64'd0);
    chk({tag, ".dout"}, bus.s_dout, 64'd0);
  endtask

  // One burst: beat k touches (a+k) mod 256; every beat's outputs predicted from ref_mem.
  task automatic burst(input bit wr, input logic [7:0] a, input logic [3:0] len, input bit noise);
    logic [7:0] ad;
    for (int k = 0; k <= int'(len); k++) begin
      ad = a + 8'(k);
      if (k == 0) begin
        bus.cen = 1'b1; bus.wen = wr; bus.s_addr = a; bus.s_len = len;
      end else if (noise) begin
        bus.cen = 1'b1; bus.wen = 1'b1; bus.s_addr = 8'd7; bus.s_len = 4'($urandom);
      end else begin
        bus.cen = 1'b0; bus.wen = 1'($urandom); bus.s_addr = 8'($urandom); bus.s_len = 4'($urandom);
      end
      bus.s_be = noise ? 8'hFF : bbe[k];
      bus.s_din = noise ? {$urandom, $urandom} : bd[k];
      tick();
      if (wr) begin
        for (int i = 0; i < 8; i++) if (bbe[k][i]) ref_mem[ad][i*8 +: 8] = bd[k][i*8 +: 8];
        chk("wbeat.dvalid", 64'(bus.s_dvalid), 64'd0);
        chk("wbeat.dout", bus.s_dout, 64'd0);
      end else begin
        chk("rbeat.dvalid", 64'(bus.s_dvalid), 64'd1);
        chk("rbeat.dout", bus.s_dout, ref_mem[ad]);
      end
      chk("beat.done", 64'(bus.done), 64'(k == int'(len)));
      chk("beat.busy", 64'(bus.busy), 64'(k != int'(len)));
    end
    bus.cen = 1'b0;
    tick();
    chk_idle("after");
  endtask

  initial begin
    logic [7:0] ra;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    bus.cen = 1'b1; bus.wen = 1'b1; bus.s_addr = 8'd3; bus.s_len = 4'd0;
    bus.s_be = 8'hFF; bus.s_din = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    tick();
    chk_idle("reset");
    bus.cen = 1'b0;
    rst = 1'b0;
    tick();
    chk_idle("post_reset");
    // Single write then read at addr 5
    bd[0] = 64'h0123_4567_89AB_CDEF; bbe[0] = 8'hFF;
    burst(1'b1, 8'd5, 4'd0, 1'b0);
    burst(1'b0, 8'd5, 4'd0, 1'b0);
    bus.cen = 1'b1; bus.wen = 1'b0; bus.s_addr = 8'd5; bus.s_len = 4'd0;
    tick();
    bus.cen = 1'b0;
    chk("single.dout", bus.s_dout, 64'h0123_4567_89AB_CDEF);
    tick();
    chk_idle("single.after");
    // Byte mask on a never-written word
    bd[0] = '1; bbe[0] = 8'h0F;
    burst(1'b1, 8'd9, 4'd0, 1'b0);
    burst(1'b0, 8'd9, 4'd0, 1'b0);
    chk("mask.model", ref_mem[9], 64'h0000_0000_FFFF_FFFF);
    // Wrap burst around the top of memory
    for (int k = 0; k < 4; k++) begin bd[k] = 64'(k + 1); bbe[k] = 8'hFF; end
    burst(1'b1, 8'd254, 4'd3, 1'b0);
    burst(1'b0, 8'd254, 4'd3, 1'b0);
    // Requests during a busy read are ignored
    burst(1'b0, 8'd0, 4'd3, 1'b1);
    burst(1'b0, 8'd7, 4'd0, 1'b0);
    // Reset mid-burst: 3 of 8 beats land
    for (int k = 0; k < 8; k++) begin bd[k] = 64'(16 + k); bbe[k] = 8'hFF; end
    for (int k = 0; k < 3; k++) begin
      bus.cen = (k == 0); bus.wen = 1'b1; bus.s_addr = 8'd16; bus.s_len = 4'd7;
      bus.s_be = bbe[k]; bus.s_din = bd[k];
      tick();
      ref_mem[16 + k] = bd[k];
    end
    chk("abort.busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk_idle("abort.now");
    bus.cen = 1'b1; bus.wen = 1'b1; bus.s_addr = 8'd40; bus.s_len = 4'd0;
    bus.s_be = 8'hFF; bus.s_din = 64'h5555_AAAA_5555_AAAA;
    tick();
    chk_idle("abort.held");
    rst = 1'b0;
    bus.cen = 1'b0;
    tick();
    burst(1'b0, 8'd16, 4'd7, 1'b0);
    burst(1'b0, 8'd40, 4'd0, 1'b0);
    chk("abort.model19", ref_mem[19], 64'd0);
    // Back-to-back reads with cen held high
    ra = 8'($urandom);
    bus.cen = 1'b1; bus.wen = 1'b0; bus.s_addr = ra; bus.s_len = 4'd1;
    for (int c = 0; c < 9; c++) begin
      tick();
      chk("b2b.dvalid", 64'(bus.s_dvalid), 64'(c % 3 != 2));
      chk("b2b.dout", bus.s_dout, c % 3 == 2 ? 64'd0 : ref_mem[8'(ra + 8'(c % 3))]);
    end
    bus.cen = 1'b0;
    tick();
    tick();
    chk_idle("b2b.after");
    // Randomized bursts, each followed by a full readback
    for (int n = 0; n < 8; n++) begin
      ra = 8'($urandom);
      for (int k = 0; k < 16; k++) begin
        bd[k] = {$urandom, $urandom};
        bbe[k] = 8'($urandom);
      end
      burst(1'b1, ra, 4'($urandom_range(0, 15)), 1'b0);
      burst(1'b0, ra, 4'd15, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/burst_ram.md
BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 Parameter DATA_W, default 64, data word width; multiple of 8.
REQ-002 Parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter LEN_W, default 4, burst-length field width; maximum burst 2**LEN_W beats.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port cen  input  1  request strobe; sampled only while idle.
REQ-007 Port wen  input  1  1 = write burst, 0 = read burst; sampled with cen.
REQ-008 Port s_addr  input  ADDR_W  burst start address; sampled with cen.
REQ-009 Port s_len  input  LEN_W  beats minus one; sampled with cen.
REQ-010 Port s_be  input  DATA_W/8  byte enables for the current write beat.
REQ-011 Port s_din  input  DATA_W  write data for the current write beat.
REQ-012 Port s_dout  output  DATA_W  registered read data.
REQ-013 Port s_dvalid  output  1  s_dout holds a valid read beat.
REQ-014 Port busy  output  1  burst in progress; new requests ignored.
REQ-015 Port done  output  1  one-cycle pulse marking the final beat.

Function
REQ-016 Storage: DEPTH x DATA_W array; all words zero at time zero; rst SHALL NOT alter contents.
REQ-017 FSM states IDLE, WBURST, RBURST; busy = 1 in WBURST and RBURST, 0 in IDLE.
REQ-018 Accept: edge where state = IDLE and cen = 1 accepts; wen, s_addr and s_len are latched; beat 0 executes on that same edge.
REQ-019 Beat k (k = 0..s_len) uses address (s_addr + k) mod DEPTH; wrap from DEPTH-1 to 0 is silent.
REQ-020 Transition: s_len = 0 stays IDLE after accept; otherwise goes to WBURST/RBURST, executes one beat per edge, and returns to IDLE on the edge executing beat s_len.
REQ-021 Write beat: for each byte i with s_be[i] = 1, mem byte i <= s_din byte i; bytes with s_be[i] = 0 unchanged; s_be = 0 is a legal no-op beat.
REQ-022 Write beats consume s_din/s_be every cycle; no stall.
REQ-023 Read beat: s_dout <= mem[addr], s_dvalid <= 1 on that edge, giving latency 1; s_dvalid is high for exactly s_len+1 consecutive cycles.
REQ-024 Outside read beats, s_dout <= 0 and s_dvalid <= 0 on every edge, including write beats and idle.
REQ-025 done <= 1 on the edge executing beat s_len (read or write), 0 otherwise; for reads it coincides with the last s_dvalid cycle.
REQ-026 While busy, cen, wen, s_addr and s_len are ignored; a request held across the last beat is accepted on the first edge at which state is back in IDLE, so there is at least 1 idle cycle between bursts.
REQ-027 A read after a write to the same address returns the new data; there is no read/write overlap within one block.
REQ-028 Beat counter width LEN_W; there is no overflow, since the counter never exceeds s_len.

Reset
REQ-029 rst = 1 immediately forces state IDLE, beat counter 0, s_dout = 0, s_dvalid = 0, busy = 0, done = 0.
REQ-030 rst mid-burst aborts the burst; beats already written remain in memory, and no further beats execute.
REQ-031 A request with cen = 1 while rst = 1 is not accepted; acceptance is possible from the first edge after rst falls.

Verification
REQ-032 Single write/read: write 64'h0123_4567_89AB_CDEF at addr 5, s_len = 0, s_be = FF; then read addr 5 -> s_dout = 64'h0123_4567_89AB_CDEF, s_dvalid = 1 and done = 1 for exactly 1 cycle, 1 cycle after accept.
REQ-033 Byte mask: mem[9] = 0; write 64'hFFFF_FFFF_FFFF_FFFF at addr 9 with s_be = 8'h0F; read -> 64'h0000_0000_FFFF_FFFF.
REQ-034 Wrap burst: write burst at addr 254, s_len = 3, data 1,2,3,4; read burst at addr 254, s_len = 3 -> beats 1,2,3,4 from addresses 254,255,0,1; busy = 1 for 3 cycles; done with beat 4.
REQ-035 Busy ignore: during a 4-beat read at addr 0, pulse cen with wen = 1 at addr 7 -> mem[7] unchanged and the read data sequence is undisturbed.
REQ-036 Reset mid-burst: 8-beat write at addr 16, data 16+k; assert rst after 3 beats -> mem[16..18] written, mem[19..23] = 0; all outputs 0 immediately.
REQ-037 Back-to-back: cen held high with s_len = 1 reads -> accepts every 3rd cycle; s_dvalid pattern 1,1,0 repeating.
